// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with configurable width, parity and stop bits.
// Words are delivered through a valid/ready holding register with error flags.
module uart_rx_os #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 rx_busy
);

   // state  | meaning
   // IDLE   | waiting for a falling edge on rxs
   // START  | counting to the start-bit midpoint, then confirming low
   // DATA   | sampling DATA_BITS bits, LSB first
   // PARITY | sampling the parity bit and checking it
   // STOP   | sampling STOP_BITS stop bits; last sample completes the frame
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = $clog2(DIV + 1);
   localparam int OW      = $clog2(OVERSAMPLE);

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   logic                 rx_meta;
   logic                 rxs;
   logic                 rxs_d;
   logic                 fall;
   logic [DW-1:0]        div_cnt;
   logic                 tick;

   state_t               state;
   state_t               state_nxt;
   logic [OW-1:0]        os_cnt;
   logic [OW-1:0]        os_nxt;
   logic [3:0]           bit_cnt;
   logic [3:0]           bit_nxt;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_nxt;
   logic                 perr_r;
   logic                 perr_nxt;
   logic                 ferr_r;
   logic                 ferr_nxt;
   logic                 complete;
   logic                 start_clr;
   logic                 load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
      end
   end

   assign fall = rxs_d & ~rxs;
   assign tick = (div_cnt == DIV_LAST);

   // Cleared on entering START so ticks are phase-aligned to the start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (start_clr || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         os_cnt  <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;
      end else begin
         state   <= state_nxt;
         os_cnt  <= os_nxt;
         bit_cnt <= bit_nxt;
         shift   <= shift_nxt;
         perr_r  <= perr_nxt;
         ferr_r  <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      os_nxt    = os_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      perr_nxt  = perr_r;
      ferr_nxt  = ferr_r;
      complete  = 1'b0;
      start_clr = 1'b0;

      case (state)
         S_IDLE: begin
            if (fall) begin
               state_nxt = S_START;
               os_nxt    = OS_HALF;
               start_clr = 1'b1;
               perr_nxt  = 1'b0;
               ferr_nxt  = 1'b0;
            end
         end
         S_START: begin
            if (tick) begin
               if (os_cnt == '0) begin
                  if (!rxs) begin
                     state_nxt = S_DATA;
                     os_nxt    = OS_LAST;
                     bit_nxt   = DATA_LAST;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end else begin
                  os_nxt = os_cnt - OW'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (os_cnt == '0) begin
                  shift_nxt = {rxs, shift[DATA_BITS-1:1]};
                  os_nxt    = OS_LAST;
                  if (bit_cnt == '0) begin
                     bit_nxt = STOP_LAST;
                     if (PARITY != 0) begin
                        state_nxt = S_PARITY;
                     end else begin
                        state_nxt = S_STOP;
                     end
                  end else begin
                     bit_nxt = bit_cnt - 4'd1;
                  end
               end else begin
                  os_nxt = os_cnt - OW'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               if (os_cnt == '0) begin
                  // Odd mode needs an odd total count of ones, even mode an even one.
                  if (PARITY == 1) begin
                     perr_nxt = ~(^shift ^ rxs);
                  end else begin
                     perr_nxt = ^shift ^ rxs;
                  end
                  state_nxt = S_STOP;
                  os_nxt    = OS_LAST;
                  bit_nxt   = STOP_LAST;
               end else begin
                  os_nxt = os_cnt - OW'(1);
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (os_cnt == '0) begin
                  if (!rxs) begin
                     ferr_nxt = 1'b1;
                  end
                  os_nxt = OS_LAST;
                  if (bit_cnt == '0) begin
                     complete  = 1'b1;
                     state_nxt = S_IDLE;
                  end else begin
                     bit_nxt = bit_cnt - 4'd1;
                  end
               end else begin
                  os_nxt = os_cnt - OW'(1);
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Disabling drops any partial frame; the holding register is left alone.
      if (!rx_en) begin
         state_nxt = S_IDLE;
         complete  = 1'b0;
         start_clr = 1'b0;
      end
   end

   assign rx_busy = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);

   // A word consumed in the same clock frees the register for the new frame.
   assign load = complete & (~data_valid | data_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= complete & data_valid & ~data_ready;
         if (load) begin
            data_out   <= shift;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
            data_valid <= 1'b1;
         end else if (data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three configurations (8N1, 7E1, 8N2) on separate
// lines, expected words queued at send time and popped when the receiver holds them.
module tb_uart_rx_os;

   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 115200;
   localparam int OS       = 16;
   localparam int DIV      = CLK_FREQ / (BAUD * OS);
   localparam int BIT      = DIV * OS;
   // posedges from driving the start bit to the completion edge of an 8N1 frame
   localparam int LAT_8N1  = (OS / 2 + OS * 9) * DIV + 3;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] rx;
   logic [2:0] rx_en;
   logic [2:0] rdy;
   wire  [2:0] vld;
   wire  [2:0] pe;
   wire  [2:0] fe;
   wire  [2:0] ov;
   wire  [2:0] busy;
   wire  [7:0] d0;
   wire  [6:0] d1;
   wire  [7:0] d2;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   ovr_cnt[3] = '{0, 0, 0};
   int   busy_cnt0 = 0;

   always #10 clk = ~clk;

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .rx_en(rx_en[0]), .rx(rx[0]), .data_out(d0),
      .data_valid(vld[0]), .data_ready(rdy[0]), .parity_err(pe[0]),
      .frame_err(fe[0]), .overrun_err(ov[0]), .rx_busy(busy[0]));

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
      .clk(clk), .rst(rst), .rx_en(rx_en[1]), .rx(rx[1]), .data_out(d1),
      .data_valid(vld[1]), .data_ready(rdy[1]), .parity_err(pe[1]),
      .frame_err(fe[1]), .overrun_err(ov[1]), .rx_busy(busy[1]));

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .rst(rst), .rx_en(rx_en[2]), .rx(rx[2]), .data_out(d2),
      .data_valid(vld[2]), .data_ready(rdy[2]), .parity_err(pe[2]),
      .frame_err(fe[2]), .overrun_err(ov[2]), .rx_busy(busy[2]));

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (ov[i]) ovr_cnt[i]++;
      end
      if (busy[0]) busy_cnt0++;
   end

   function automatic logic [8:0] dq(input int i);
      case (i)
         0:       return {1'b0, d0};
         1:       return {2'b0, d1};
         default: return {1'b0, d2};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bit_wait();
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic send(input int idx, input logic [8:0] d, input int nb, input int pmode,
                       input bit pflip, input int nstop, input bit last_stop);
      logic p;
      p = 1'b0;
      @(posedge clk);
      #1;
      rx[idx] = 1'b0;
      bit_wait();
      for (int i = 0; i < nb; i++) begin
         rx[idx] = d[i];
         p = p ^ d[i];
         bit_wait();
      end
      if (pmode != 0) begin
         rx[idx] = ((pmode == 1) ? ~p : p) ^ pflip;
         bit_wait();
      end
      for (int i = 0; i < nstop; i++) begin
         rx[idx] = (i == nstop - 1) ? last_stop : 1'b1;
         bit_wait();
      end
      rx[idx] = 1'b1;
   endtask

   task automatic check_word(input int idx, input bit rel, input string tag);
      exp_t e;
      for (int i = 0; i < 3 * BIT && vld[idx] !== 1'b1; i++) @(negedge clk);
      chk({tag, "_valid"}, 9'(vld[idx]), 9'd1);
      chk({tag, "_sb"}, 9'(sb.size() != 0), 9'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({tag, "_data"}, dq(idx), e.data);
      chk({tag, "_perr"}, 9'(pe[idx]), 9'(e.perr));
      chk({tag, "_ferr"}, 9'(fe[idx]), 9'(e.ferr));
      if (rel) begin
         @(posedge clk);
         #1;
         rdy[idx] = 1'b1;
         @(posedge clk);
         #1;
         rdy[idx] = 1'b0;
         @(negedge clk);
         chk({tag, "_clear"}, 9'(vld[idx]), 9'd0);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int o;
      rst   = 1'b1;
      rx    = 3'b111;
      rx_en = 3'b000;
      rdy   = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 9'(vld[0]), 9'd0);
      chk("rst_data", dq(0), 9'h000);
      chk("rst_perr", 9'(pe[0]), 9'd0);
      chk("rst_ferr", 9'(fe[0]), 9'd0);
      chk("rst_ovr", 9'(ov[0]), 9'd0);
      chk("rst_busy", 9'(busy[0]), 9'd0);
      chk("rst_valid_7e1", 9'(vld[1]), 9'd0);
      chk("rst_valid_8n2", 9'(vld[2]), 9'd0);
      rst   = 1'b0;
      rx_en = 3'b111;
      repeat (5) @(posedge clk);

      sb.push_back('{9'h0A5, 1'b0, 1'b0});
      send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
      check_word(0, 1'b1, "a5");

      b = busy_cnt0;
      @(posedge clk);
      #1;
      rx[0] = 1'b0;
      repeat (4 * DIV) @(posedge clk);
      #1;
      rx[0] = 1'b1;
      repeat (BIT) @(posedge clk);
      #1;
      chk("fs_busy", 9'(busy_cnt0 - b), 9'd0);
      chk("fs_valid", 9'(vld[0]), 9'd0);
      sb.push_back('{9'h03C, 1'b0, 1'b0});
      send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1);
      check_word(0, 1'b1, "3c");

      o = ovr_cnt[0];
      sb.push_back('{9'h011, 1'b0, 1'b0});
      send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
      send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
      chk("ovr_pulse", 9'(ovr_cnt[0] - o), 9'd1);
      check_word(0, 1'b0, "ovr_hold");

      sb.push_back('{9'h055, 1'b0, 1'b0});
      fork
         send(0, 9'h055, 8, 0, 1'b0, 1, 1'b1);
         begin
            @(posedge clk);
            #1;
            repeat (LAT_8N1 - 1) @(posedge clk);
            #1;
            rdy[0] = 1'b1;
            @(posedge clk);
            #1;
            rdy[0] = 1'b0;
         end
      join
      chk("same_clk_ovr", 9'(ovr_cnt[0] - o), 9'd1);
      check_word(0, 1'b1, "same_clk");

      sb.push_back('{9'h055, 1'b0, 1'b0});
      send(1, 9'h055, 7, 2, 1'b0, 1, 1'b1);
      check_word(1, 1'b1, "par_ok");
      sb.push_back('{9'h055, 1'b1, 1'b0});
      send(1, 9'h055, 7, 2, 1'b1, 1, 1'b1);
      check_word(1, 1'b1, "par_bad");

      sb.push_back('{9'h081, 1'b0, 1'b1});
      send(2, 9'h081, 8, 0, 1'b0, 2, 1'b0);
      check_word(2, 1'b1, "frame");

      sb.push_back('{9'h05A, 1'b0, 1'b0});
      send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
      check_word(0, 1'b0, "hold5a");
      fork
         send(0, 9'h099, 8, 0, 1'b0, 1, 1'b1);
         begin
            @(posedge clk);
            #1;
            repeat (3 * BIT) @(posedge clk);
            #1;
            chk("abort_busy_hi", 9'(busy[0]), 9'd1);
            rx_en[0] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("abort_busy_lo", 9'(busy[0]), 9'd0);
         end
      join
      chk("abort_valid", 9'(vld[0]), 9'd1);
      chk("abort_data", dq(0), 9'h05A);
      rx_en[0] = 1'b1;
      repeat (10) @(posedge clk);

      fork
         send(0, 9'h0C3, 8, 0, 1'b0, 1, 1'b1);
         begin
            @(posedge clk);
            #1;
            repeat (2 * BIT) @(posedge clk);
            #1;
            chk("rstmid_busy_hi", 9'(busy[0]), 9'd1);
            rst = 1'b1;
            #1;
            chk("rstmid_valid", 9'(vld[0]), 9'd0);
            chk("rstmid_data", dq(0), 9'h000);
            chk("rstmid_busy", 9'(busy[0]), 9'd0);
         end
      join
      rst = 1'b0;
      repeat (5) @(posedge clk);

      sb.push_back('{9'h0F0, 1'b0, 1'b0});
      send(0, 9'h0F0, 8, 0, 1'b0, 1, 1'b1);
      check_word(0, 1'b1, "f0");
      chk("sb_empty", 9'(sb.size()), 9'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
